// File: rtl/filter_out_capture.sv
// Decimating capture FIFO for filter output samples, drained over a valid/ready port.
// Define FILTER_OUT_CAPTURE_MINMAX_EN to add running signed min/max of pushed samples.
module filter_out_capture #(
    parameter int WIDTH = 25,
    parameter int DEPTH = 16,
    parameter int DEC_W = 8
) (
    input  logic                       emu_clk,
    input  logic                       emu_rst_n,
    input  logic [WIDTH-1:0]           in_data,
    input  logic                       in_valid,
    input  logic                       enable,
    input  logic                       clr,
    input  logic [DEC_W-1:0]           dec_ratio,
    output logic [WIDTH-1:0]           out_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [$clog2(DEPTH):0]     count,
`ifdef FILTER_OUT_CAPTURE_MINMAX_EN
    output logic signed [WIDTH-1:0]    min_data,
    output logic signed [WIDTH-1:0]    max_data,
`endif
    output logic                       overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [DEC_W-1:0] dec_cnt;
    logic [DEC_W-1:0] ratio_m1;
    logic             hit;
    logic             full;
    logic             pop;
    logic             push_ok;
    logic             drop;

    // Ratio 0 behaves as 1. Using >= lets a lowered ratio fire on the very next sample.
    assign ratio_m1 = (dec_ratio == '0) ? '0 : dec_ratio - DEC_W'(1);
    assign hit      = in_valid && enable && (dec_cnt >= ratio_m1);
    assign full     = (count == CW'(DEPTH));

    // Output handshake: the head transfers on any cycle where out_valid and out_ready
    // are both high; out_valid never depends on out_ready and stays high while count>0.
    assign out_valid = (count != '0);
    assign out_data  = out_valid ? mem[rd_ptr] : '0;

    assign pop     = out_valid && out_ready && !clr;
    assign push_ok = hit && (!full || pop) && !clr;
    assign drop    = hit && full && !pop && !clr;

    always_ff @(posedge emu_clk or negedge emu_rst_n) begin
        if (!emu_rst_n) begin
            dec_cnt <= '0;
        end else if (clr || !enable) begin
            dec_cnt <= '0;
        end else if (in_valid) begin
            dec_cnt <= hit ? '0 : dec_cnt + DEC_W'(1);
        end
    end

    always_ff @(posedge emu_clk or negedge emu_rst_n) begin
        if (!emu_rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else if (clr) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + AW'(1);
            if (pop)     rd_ptr <= rd_ptr + AW'(1);
            if (push_ok && !pop)      count <= count + CW'(1);
            else if (pop && !push_ok) count <= count - CW'(1);
            if (drop) overflow <= 1'b1;
        end
    end

    // When full with a same-cycle pop, wr_ptr equals rd_ptr: the slot being vacated is reused.
    always_ff @(posedge emu_clk) begin
        if (push_ok) mem[wr_ptr] <= in_data;
    end

`ifdef FILTER_OUT_CAPTURE_MINMAX_EN
    logic seen;

    always_ff @(posedge emu_clk or negedge emu_rst_n) begin
        if (!emu_rst_n) begin
            seen     <= 1'b0;
            min_data <= '0;
            max_data <= '0;
        end else if (clr) begin
            seen     <= 1'b0;
            min_data <= '0;
            max_data <= '0;
        end else if (push_ok) begin
            seen <= 1'b1;
            if (!seen || ($signed(in_data) < min_data)) min_data <= $signed(in_data);
            if (!seen || ($signed(in_data) > max_data)) max_data <= $signed(in_data);
        end
    end
`endif

endmodule

// File: tb/tb_filter_out_capture.sv
// Directed bench for filter_out_capture with hand-computed expectations.
// Min/max checks are compiled in when FILTER_OUT_CAPTURE_MINMAX_EN is defined.
module tb_filter_out_capture;

    localparam int W  = 25;
    localparam int D  = 16;
    localparam int DW = 8;

    logic          emu_clk = 1'b0;
    logic          emu_rst_n;
    logic [W-1:0]  in_data;
    logic          in_valid;
    logic          enable;
    logic          clr;
    logic [DW-1:0] dec_ratio;
    logic [W-1:0]  out_data;
    logic          out_valid;
    logic          out_ready;
    logic [4:0]    count;
    logic          overflow;
`ifdef FILTER_OUT_CAPTURE_MINMAX_EN
    logic [W-1:0]  min_data;
    logic [W-1:0]  max_data;
`endif

    int checks   = 0;
    int failures = 0;

    filter_out_capture #(.WIDTH(W), .DEPTH(D), .DEC_W(DW)) dut (
        .emu_clk   (emu_clk),
        .emu_rst_n (emu_rst_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .enable    (enable),
        .clr       (clr),
        .dec_ratio (dec_ratio),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .count     (count),
`ifdef FILTER_OUT_CAPTURE_MINMAX_EN
        .min_data  (min_data),
        .max_data  (max_data),
`endif
        .overflow  (overflow)
    );

    always #5 emu_clk = ~emu_clk;

    task automatic tick();
        @(posedge emu_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic pulse_clr();
        clr = 1'b1;
        tick();
        clr = 1'b0;
    endtask

    initial begin
        emu_rst_n = 1'b0;
        in_data   = '0;
        in_valid  = 1'b0;
        enable    = 1'b1;
        clr       = 1'b0;
        dec_ratio = 8'd1;
        out_ready = 1'b0;

        // Reset state
        #12;
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_data", 32'(out_data), 32'd0);
        chk("rst_ovf", 32'(overflow), 32'd0);
        tick();
        emu_rst_n = 1'b1;
        tick();

        // Ratio 1, constant sample, consumer always ready
        in_data = 25'h080000; in_valid = 1'b1; out_ready = 1'b1;
        chk("s1_pre_valid", 32'(out_valid), 32'd0);
        tick();
        chk("s1_valid", 32'(out_valid), 32'd1);
        chk("s1_data", 32'(out_data), 32'h080000);
        chk("s1_count1", 32'(count), 32'd1);
        tick();
        chk("s1_count_steady", 32'(count), 32'd1);
        chk("s1_ovf", 32'(overflow), 32'd0);
        in_valid = 1'b0;
        tick();
        chk("s1_drained", 32'(count), 32'd0);

        // Ratio 4, samples 0..11, no draining: keeps 3, 7, 11
        dec_ratio = 8'd4; out_ready = 1'b0; in_valid = 1'b1;
        for (int k = 0; k < 12; k++) begin
            in_data = W'(k);
            tick();
        end
        in_valid = 1'b0;
        chk("s2_count", 32'(count), 32'd3);
        chk("s2_head0", 32'(out_data), 32'd3);
        out_ready = 1'b1;
        tick();
        chk("s2_head1", 32'(out_data), 32'd7);
        tick();
        chk("s2_head2", 32'(out_data), 32'd11);
        tick();
        chk("s2_empty", 32'(count), 32'd0);
        out_ready = 1'b0;

        // Lowering the ratio mid-count fires on the next sample
        in_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            in_data = W'(20 + k);
            tick();
        end
        chk("s2b_nopush", 32'(count), 32'd0);
        dec_ratio = 8'd2; in_data = 25'd30;
        tick();
        chk("s2b_push", 32'(count), 32'd1);
        chk("s2b_data", 32'(out_data), 32'd30);
        in_data = 25'd31;
        tick();
        chk("s2b_wrap", 32'(count), 32'd1);
        in_data = 25'd32;
        tick();
        chk("s2b_next", 32'(count), 32'd2);
        in_valid = 1'b0;
        pulse_clr();

        // Overflow: 17 pushes into 16 entries, then push+pop at full
        dec_ratio = 8'd1; in_valid = 1'b1;
        for (int i = 0; i < 17; i++) begin
            in_data = W'(100 + i);
            tick();
        end
        chk("s3_full", 32'(count), 32'd16);
        chk("s3_ovf", 32'(overflow), 32'd1);
        chk("s3_head", 32'(out_data), 32'd100);
        out_ready = 1'b1;
        for (int j = 0; j < 4; j++) begin
            in_data = W'(200 + j);
            tick();
        end
        chk("s3_full_pp", 32'(count), 32'd16);
        chk("s3_head_pp", 32'(out_data), 32'd104);
        chk("s3_ovf_sticky", 32'(overflow), 32'd1);
        in_valid = 1'b0;
        for (int i = 0; i < 11; i++) tick();
        chk("s3_last_kept", 32'(out_data), 32'd115);
        tick();
        chk("s3_no_17th", 32'(out_data), 32'd200);
        chk("s3_count_after", 32'(count), 32'd4);
        out_ready = 1'b0;
        pulse_clr();
        chk("s3_clr_count", 32'(count), 32'd0);
        chk("s3_clr_ovf", 32'(overflow), 32'd0);

        // Ratio 0 acts as 1; disabled capture makes no pushes and holds counter at 0
        dec_ratio = 8'd0; in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_data = W'(1 + i);
            tick();
        end
        chk("s4_ratio0", 32'(count), 32'd3);
        enable = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        chk("s4_disabled", 32'(count), 32'd3);
        enable = 1'b1; dec_ratio = 8'd2; in_data = 25'd9;
        tick();
        chk("s4_cnt_zero", 32'(count), 32'd3);
        tick();
        chk("s4_resume", 32'(count), 32'd4);
        in_valid = 1'b0;
        pulse_clr();

        // Async reset mid-stream with 5 held and a partial decimation
        dec_ratio = 8'd1; in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            in_data = W'(50 + i);
            tick();
        end
        dec_ratio = 8'd3;
        tick();
        tick();
        chk("s5_held", 32'(count), 32'd5);
        in_valid = 1'b0;
        emu_rst_n = 1'b0;
        #2;
        chk("s5_async_count", 32'(count), 32'd0);
        chk("s5_async_valid", 32'(out_valid), 32'd0);
        chk("s5_async_data", 32'(out_data), 32'd0);
        tick();
        emu_rst_n = 1'b1;
        in_valid = 1'b1; in_data = 25'd77;
        tick();
        tick();
        chk("s5_rst_partial", 32'(count), 32'd0);
        tick();
        chk("s5_rst_third", 32'(count), 32'd1);
        chk("s5_rst_data", 32'(out_data), 32'd77);

        // Same via clr, with overflow set beforehand
        dec_ratio = 8'd1;
        for (int i = 0; i < 16; i++) tick();
        chk("s5_ovf_set", 32'(overflow), 32'd1);
        dec_ratio = 8'd3;
        pulse_clr();
        chk("s5_clr_count", 32'(count), 32'd0);
        chk("s5_clr_ovf", 32'(overflow), 32'd0);
        in_data = 25'd88;
        tick();
        tick();
        chk("s5_clr_partial", 32'(count), 32'd0);
        tick();
        chk("s5_clr_third", 32'(count), 32'd1);
        in_valid = 1'b0;
        pulse_clr();

`ifdef FILTER_OUT_CAPTURE_MINMAX_EN
        // Running signed min/max
        chk("mm_zero_min", 32'(min_data), 32'd0);
        chk("mm_zero_max", 32'(max_data), 32'd0);
        dec_ratio = 8'd1; in_valid = 1'b1;
        in_data = 25'h1FFFFFD; tick();
        in_data = 25'h0000007; tick();
        in_data = 25'h1FFFFF6; tick();
        in_data = 25'h0000002; tick();
        in_valid = 1'b0;
        chk("mm_min", 32'(min_data), 32'h1FFFFF6);
        chk("mm_max", 32'(max_data), 32'h0000007);
        pulse_clr();
        in_valid = 1'b1; in_data = 25'd5;
        tick();
        in_valid = 1'b0;
        chk("mm_clr_min", 32'(min_data), 32'd5);
        chk("mm_clr_max", 32'(max_data), 32'd5);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
